// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared types and constants for the seven-segment scanner:
//            FSM state encoding, blank pattern, hex decode table and the
//            digit-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Scanner states; BLANK separates digit slots to prevent ghosting.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Width of the digit index register.
    function automatic int idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seven_seg
// Purpose  : Combinational hex nibble to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexes a hex value onto a common-anode multi-digit
//            seven-segment display, one digit per slot with a single
//            blanking cycle between slots.
// Options  : SEVEN_SEG_BLANK_LEADING_ZEROS_EN - when defined, digits whose
//            nibble and all higher nibbles are zero are kept dark (digit 0
//            is always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int TICK_W = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  value_we_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  mask_we_i,
    input  logic [DIGITS-1:0]     mask_i,
    input  logic                  dp_we_i,
    input  logic [DIGITS-1:0]     dp_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int              IW       = idx_w(DIGITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   mask_q;
    logic [DIGITS-1:0]   point_q;
    logic [TICK_W-1:0]   cnt_q;
    logic [0:0]          state_q, state_d;
    logic [IW-1:0]       index_q, index_d;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                dp_out_q;
    logic                frame_q;

    logic                w_tick;
    logic [3:0]          w_nibbles [DIGITS];
    logic [3:0]          w_nibble;
    logic [6:0]          w_seg;
    logic                w_en;
    logic [DIGITS-1:0]   w_an;

    assign w_tick = &cnt_q;

    // Register file: each strobe loads its register independently.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value_q <= '0;
            mask_q  <= '1;
            point_q <= '0;
        end else begin
            if (value_we_i) value_q <= value_i;
            if (mask_we_i)  mask_q  <= mask_i;
            if (dp_we_i)    point_q <= dp_i;
        end
    end

    // Free-running slot counter; the all-ones value ends a DRIVE period.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_q + 1'b1;
    end

    // Next state: DRIVE until tick, BLANK for one cycle while the index steps.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            ST_DRIVE: begin
                if (w_tick) state_d = ST_BLANK;
            end
            default: begin
                state_d = ST_DRIVE;
                index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
            end
        endcase
    end

    // State and digit index registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_BLANK;
            index_q <= LAST_IDX;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_nibble
            assign w_nibbles[k] = value_q[4*k +: 4];
        end
    endgenerate

    assign w_nibble = w_nibbles[index_d];

    hex_to_seven_seg u_decode (
        .nibble_i (w_nibble),
        .seg_o    (w_seg)
    );

`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
    logic [DIGITS-1:0] w_lz;

    // Walk down from the top nibble; a digit is a leading zero while every
    // nibble from the top down to it is zero. Digit 0 is never suppressed.
    always_comb begin
        logic v_zero;
        v_zero = 1'b1;
        w_lz   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            v_zero  = v_zero & (w_nibbles[k] == 4'h0);
            w_lz[k] = v_zero;
        end
    end

    assign w_en = mask_q[index_d] & ~w_lz[index_d];
`else
    assign w_en = mask_q[index_d];
`endif

    // Anode pattern for the digit about to be driven (all high when disabled).
    always_comb begin
        w_an = '1;
        if (w_en) w_an[index_d] = 1'b0;
    end

    // Output registers: loaded with the snapshot on BLANK->DRIVE, cleared on
    // DRIVE->BLANK, held otherwise so mid-slot writes do not disturb a digit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dp_out_q <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (state_q == ST_BLANK) begin
                an_q     <= w_an;
                seg_q    <= w_seg;
                dp_out_q <= ~point_q[index_d];
            end else if (w_tick) begin
                an_q     <= '1;
                seg_q    <= SEG_OFF;
                dp_out_q <= 1'b1;
                frame_q  <= (index_q == LAST_IDX);
            end
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_out_q;
    assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Self-checking bench for seven_seg_scanner (DIGITS=8, TICK_W=4)
//            with a slot-arithmetic reference model. Honours
//            SEVEN_SEG_BLANK_LEADING_ZEROS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int DIGITS = 8;
    localparam int TICK_W = 4;
    localparam int SLOT   = 16;
    localparam int FRAME  = 128;
`ifdef SEVEN_SEG_BLANK_LEADING_ZEROS_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        value_we_i = 1'b0;
    logic [31:0] value_i = '0;
    logic        mask_we_i = 1'b0;
    logic [7:0]  mask_i = '0;
    logic        dp_we_i = 1'b0;
    logic [7:0]  dp_i = '0;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(.DIGITS(DIGITS), .TICK_W(TICK_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .value_we_i(value_we_i), .value_i(value_i),
        .mask_we_i(mask_we_i), .mask_i(mask_i),
        .dp_we_i(dp_we_i), .dp_i(dp_i),
        .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [6:0]  ref_dec [16];
    logic [31:0] m_val;
    logic [7:0]  m_mask, m_dp;
    int          t;          // clock edges since reset release
    int          s_dig;
    logic [3:0]  s_nib;
    logic        s_en, s_dp;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;

    function automatic bit lead_zero(input logic [31:0] v, input int d);
        return LZ_ON && (d != 0) && ((v >> (4 * d)) == 32'h0);
    endfunction

    task automatic model_reset();
        m_val = '0; m_mask = 8'hFF; m_dp = '0; t = 0;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    endtask

    // One clock: slot k occupies edges 16k+1..16k+15 for digit k mod 8, edge
    // 16k is blank; the digit is captured from the registers before writes.
    task automatic cyc();
        int n;
        @(posedge clk_i);
        n = t + 1;
        if (n % SLOT == 1) begin
            s_dig = (n / SLOT) % DIGITS;
            s_nib = m_val[4*s_dig +: 4];
            s_en  = m_mask[s_dig] && !lead_zero(m_val, s_dig);
            s_dp  = m_dp[s_dig];
        end
        if (value_we_i) m_val  = value_i;
        if (mask_we_i)  m_mask = mask_i;
        if (dp_we_i)    m_dp   = dp_i;
        t = n;
        if (t % SLOT == 0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            e_frame = (t % FRAME == 0);
        end else begin
            e_an = s_en ? ~(8'h01 << s_dig) : 8'hFF;
            e_seg = ref_dec[s_nib];
            e_dp = ~s_dp;
            e_frame = 1'b0;
        end
        @(negedge clk_i);
        value_we_i = 1'b0; mask_we_i = 1'b0; dp_we_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_hold got %h want %h", {an_o, seg_o, dp_o, frame_o}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        rst_i = 1'b1;
        model_reset();
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
            errors++; $display("FAIL reset_release t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
        end
        for (int i = 0; i < 17; i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL reset_slot t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
            if (t == 1) begin
                checks++;
                if ({an_o, seg_o} !== {8'hFE, 7'b1000000}) begin
                    errors++; $display("FAIL first_digit got %h want %h", {an_o, seg_o}, {8'hFE, 7'b1000000});
                end
            end
        end
    endtask

    task automatic test_value_frame();
        int pulses;
        value_i = 32'h0123_4567; value_we_i = 1'b1;
        for (int i = 0; i < 2 * FRAME && (i == 0 || t % FRAME != 0); i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL value_align t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
        end
        pulses = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            if (frame_o === 1'b1) pulses++;
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL value_frame t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
            if (t % SLOT == 8) begin
                checks++;
                if ({an_o, seg_o} !== {~(8'h01 << ((t / SLOT) % DIGITS)), ref_dec[7 - (t / SLOT) % DIGITS]}) begin
                    errors++; $display("FAIL value_digit t=%0d got %h", t, {an_o, seg_o});
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL frame_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_mask_dp();
        int d;
        mask_i = 8'h0F; mask_we_i = 1'b1; dp_i = 8'h01; dp_we_i = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL mask_dp t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
            if (i >= FRAME && t % SLOT == 8) begin
                d = (t / SLOT) % DIGITS;
                checks++;
                if ({an_o, dp_o} !== {(d < 4) ? ~(8'h01 << d) : 8'hFF, (d == 0) ? 1'b0 : 1'b1}) begin
                    errors++; $display("FAIL mask_digit d=%0d got an=%h dp=%b", d, an_o, dp_o);
                end
            end
        end
    endtask

    task automatic test_write_timing();
        for (int i = 0; i < 2 * FRAME && t % FRAME != 53; i++) cyc();
        value_i = 32'hFFFF_FFFF; value_we_i = 1'b1;
        for (int i = 0; i < 2 * FRAME && (i == 0 || t % FRAME != 49); i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL write_mid t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
            if (i < 10 && t % SLOT != 0) begin
                checks++;
                if (seg_o !== ref_dec[4]) begin
                    errors++; $display("FAIL write_hold t=%0d got %b want %b", t, seg_o, ref_dec[4]);
                end
            end
        end
        checks++;
        if (seg_o !== 7'b0001110) begin
            errors++; $display("FAIL write_next_slot got %b want 0001110", seg_o);
        end
        for (int i = 0; i < 2 * FRAME && t % FRAME != 64; i++) cyc();
        value_i = 32'h5555_5555; value_we_i = 1'b1;
        cyc();
        checks++;
        if (seg_o !== 7'b0001110) begin
            errors++; $display("FAIL write_blank_old got %b want 0001110", seg_o);
        end
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL write_blank t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0) begin value_i = $urandom; value_we_i = 1'b1; end
            if ($urandom_range(0, 39) == 0) begin mask_i = 8'($urandom); mask_we_i = 1'b1; end
            if ($urandom_range(0, 39) == 0) begin dp_i = 8'($urandom); dp_we_i = 1'b1; end
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL random t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
        end
    endtask

    task automatic test_async_reset();
        mask_i = 8'hFF; mask_we_i = 1'b1; value_i = 32'h89AB_CDEF; value_we_i = 1'b1;
        cyc();
        for (int i = 0; i < 2 * FRAME && t % FRAME != 23; i++) cyc();
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL async_reset got %h want %h", {an_o, seg_o, dp_o, frame_o}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        for (int i = 0; i < 17; i++) begin
            cyc();
            checks++;
            if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                errors++; $display("FAIL async_release t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
            end
            if (t == 5) begin
                checks++;
                if ({an_o, seg_o} !== {8'hFE, 7'b1000000}) begin
                    errors++; $display("FAIL async_value_cleared got %h want %h", {an_o, seg_o}, {8'hFE, 7'b1000000});
                end
            end
        end
    endtask

    task automatic test_leading_zeros();
        int d;
        logic [31:0] vals [2];
        vals[0] = 32'h0000_00A0;
        vals[1] = 32'h0000_0000;
        for (int v = 0; v < 2; v++) begin
            value_i = vals[v]; value_we_i = 1'b1;
            for (int i = 0; i < 2 * FRAME && (i == 0 || t % FRAME != 0); i++) cyc();
            for (int i = 0; i < FRAME; i++) begin
                cyc();
                checks++;
                if ({an_o, seg_o, dp_o, frame_o} !== {e_an, e_seg, e_dp, e_frame}) begin
                    errors++; $display("FAIL lz_frame t=%0d got %h want %h", t, {an_o, seg_o, dp_o, frame_o}, {e_an, e_seg, e_dp, e_frame});
                end
                if (t % SLOT == 8) begin
                    d = (t / SLOT) % DIGITS;
                    checks++;
                    if (an_o !== ((LZ_ON && d != 0 && (vals[v] >> (4 * d)) == 0) ? 8'hFF : ~(8'h01 << d))) begin
                        errors++; $display("FAIL lz_digit v=%0d d=%0d got an=%h", v, d, an_o);
                    end
                end
            end
        end
    endtask

    initial begin
        ref_dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        test_reset();
        test_value_frame();
        test_mask_dp();
        test_write_timing();
        test_random();
        test_async_reset();
        test_leading_zeros();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Output-side front-panel driver: time-multiplexes a hex value onto a common-anode multi-digit seven-segment display.
- Counterpart of the button debouncing input path.
- The core writes display registers through single-cycle strobes.
- The block refreshes one digit per slot, with a blanking cycle between slots to stop ghosting.

Parameters:
DIGITS, 8, number of digits scanned (2..8)
TICK_W, 17, slot counter width; one slot lasts 2^TICK_W cycles (tests use 4)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-low
value_we_i  input  1  write strobe for value register
value_i  input  4*DIGITS  hex nibbles; nibble k shown on digit k
mask_we_i  input  1  write strobe for enable mask
mask_i  input  DIGITS  1 = digit enabled
dp_we_i  input  1  write strobe for decimal-point register
dp_i  input  DIGITS  1 = decimal point lit on digit k
an_o  output  DIGITS  anode selects, active-low, one-hot-low or all-high
seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
dp_o  output  1  decimal point, active-low
frame_o  output  1  one-cycle pulse marking the end of the digit DIGITS-1 slot

Behaviour:
- Reset state:
  - value = 0, mask = all ones, dp = 0, counter = 0
  - index = DIGITS-1, state = BLANK
  - an_o all ones, seg_o = 7'h7F, dp_o = 1, frame_o = 0
- All outputs are registered.
- Register writes:
  - Each strobe updates its register at the next clock edge. Strobes are independent and always accepted; there is no backpressure.
  - A write does not affect the digit currently lit. It becomes visible at that digit's next slot.
- Slot counter:
  - Free-running, TICK_W bits, wraps to 0.
  - tick = all counter bits set.
- FSM, two states:
  - DRIVE -> BLANK on tick.
  - BLANK -> DRIVE unconditionally after 1 cycle.
- In BLANK:
  - an_o all ones, seg_o 7'h7F, dp_o 1.
  - index advances: DIGITS-1 wraps to 0, otherwise +1.
  - The new digit's nibble, mask bit and dp bit are snapshotted from the registers as they stand before this edge.
  - If value_we_i coincides with the BLANK cycle, the old value is displayed.
- In DRIVE:
  - an_o[index] = 0 only if the snapshotted mask bit is 1; otherwise all ones.
  - seg_o = decode(nibble); dp_o = ~dp bit.
  - Masked digits still occupy their slot, so duty cycle stays uniform.
- Timing:
  - First DRIVE after reset is digit 0, lit from cycle 2 after reset release.
  - Each DRIVE lasts 2^TICK_W - 1 cycles, then 1 BLANK cycle. A frame is DIGITS * 2^TICK_W cycles.
- frame_o is high during the BLANK cycle that wraps index from DIGITS-1 to 0.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-slot forces all outputs off immediately (asynchronous). Register contents are lost.

Optional Feature:
SEVEN_SEG_BLANK_LEADING_ZEROS_EN
- Defined: at snapshot, the digit is treated as masked if its nibble and all higher nibbles are zero. Digit 0 is never blanked by this rule. The explicit mask still applies on top.
- Undefined: leading zeros are displayed as "0".

Decomposition:
- seven_seg_pkg holds:
  - state enum (BLANK, DRIVE)
  - SEG_OFF = 7'h7F
  - 16-entry active-low decode constant table
  - helper to compute index width $clog2(DIGITS)
- One combinational sub-module, hex_to_seven_seg: nibble in, active-low 7-bit pattern out. It is used in the BLANK-cycle snapshot path.

Test Plan:
All tests use TICK_W=4, DIGITS=8.
- Reset release, value 0 -> an_o stays 8'hFF for 1 cycle. Then an_o=8'hFE, seg_o=7'b1000000 for 15 cycles, then 1 cycle with an_o=8'hFF.
- Write value 32'h0123_4567, observe full frame -> slots show digits 0..7 in order with patterns 7,6,5,4,3,2,1,0. frame_o pulses once per 128 cycles.
- mask_i=8'h0F, dp_i=8'h01 -> digits 4..7 keep an_o=8'hFF in their slots. Digit 0 shows dp_o=0; all other digits show dp_o=1.
- Write value_i=32'hFFFF_FFFF during digit 3 DRIVE -> digit 3 is unchanged until its next slot, then shows 0001110. A write coinciding with the BLANK cycle before digit 4 shows the old nibble.
- Assert rst_i low mid-slot -> same cycle an_o=8'hFF, seg_o=7'h7F; value reads back 0 after release.
- With SEVEN_SEG_BLANK_LEADING_ZEROS_EN defined, value 32'h0000_00A0 -> digits 2..7 dark, digit 1 shows 0001000, digit 0 shows 1000000. With value 0, only digit 0 is lit.
